// File: rtl/key_sync_multi.sv
// rtl/key_sync_multi.sv - multi-channel input synchroniser with edge strobes and stretched regReset
// Optional glitch filter enabled by defining SYNC_FILTER_EN.
module key_sync_multi #(
    parameter int                  CHANNELS   = 2,
    parameter int                  STAGES     = 2,
    parameter logic [CHANNELS-1:0] IDLE       = '1,
    parameter int                  FILTER_LEN = 4,
    parameter int                  RST_PULSE  = 16
) (
    input  logic                sysClk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] asyncIn,
    input  logic                softReset,
    output logic [CHANNELS-1:0] syncOut,
    output logic [CHANNELS-1:0] riseEdge,
    output logic [CHANNELS-1:0] fallEdge,
    output logic                regReset
);

    localparam int PW = $clog2(RST_PULSE + 1);

    if (CHANNELS < 1 || STAGES < 2 || FILTER_LEN < 1 || RST_PULSE < 1) begin : gBadParams
        $error("key_sync_multi: parameter out of range");
    end

    logic [CHANNELS-1:0] chain [STAGES];
    logic [CHANNELS-1:0] sample;
    logic [CHANNELS-1:0] syncNext;
    logic [PW-1:0]       pulseCnt;
    logic [PW-1:0]       pulseNext;
    logic                regResetNext;

    assign sample = chain[STAGES-1];

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                chain[k] <= IDLE;
            end
        end else begin
            chain[0] <= asyncIn;
            for (int k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

`ifdef SYNC_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FW-1:0] filtCnt  [CHANNELS];
    logic [FW-1:0] filtNext [CHANNELS];

    // A channel only adopts the sampled level after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            syncNext[i] = syncOut[i];
            filtNext[i] = '0;
            if (sample[i] != syncOut[i]) begin
                if (filtCnt[i] == FW'(FILTER_LEN - 1)) begin
                    syncNext[i] = sample[i];
                end else begin
                    filtNext[i] = filtCnt[i] + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                filtCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                filtCnt[i] <= filtNext[i];
            end
        end
    end
`else
    assign syncNext = sample;
`endif

    // softReset restarts the pulse from full length; the counter saturates at zero.
    always_comb begin
        pulseNext = pulseCnt;
        if (softReset) begin
            pulseNext = PW'(RST_PULSE);
        end else if (pulseCnt != '0) begin
            pulseNext = pulseCnt - PW'(1);
        end
    end

    assign regResetNext = (pulseNext != '0);

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            pulseCnt <= PW'(RST_PULSE);
            regReset <= 1'b1;
            syncOut  <= IDLE;
            riseEdge <= '0;
            fallEdge <= '0;
        end else begin
            pulseCnt <= pulseNext;
            regReset <= regResetNext;
            syncOut  <= syncNext;
            riseEdge <= syncNext & ~syncOut & {CHANNELS{~regResetNext}};
            fallEdge <= ~syncNext & syncOut & {CHANNELS{~regResetNext}};
        end
    end

endmodule

// File: tb/tb_key_sync_multi.sv
// tb/tb_key_sync_multi.sv - self-checking bench for key_sync_multi
module tb_key_sync_multi;

    localparam int         CH    = 2;
    localparam int         ST    = 2;
    localparam int         FL    = 4;
    localparam int         RP    = 16;
    localparam logic [1:0] IDLEV = 2'b11;
`ifdef SYNC_FILTER_EN
    localparam int LAT = ST + FL;
    localparam int GLITCH_FALLS = 0;
`else
    localparam int LAT = ST + 1;
    localparam int GLITCH_FALLS = 1;
`endif

    logic          sysClk = 1'b0;
    logic          reset = 1'b0;
    logic          softReset = 1'b0;
    logic [CH-1:0] asyncIn = IDLEV;
    logic [CH-1:0] syncOut, riseEdge, fallEdge;
    logic          regReset;

    int passCnt = 0;
    int totalCnt = 0;
    bit cmpEn = 0;

    always #5 sysClk = ~sysClk;

    key_sync_multi #(
        .CHANNELS(CH), .STAGES(ST), .IDLE(IDLEV), .FILTER_LEN(FL), .RST_PULSE(RP)
    ) dut (
        .sysClk(sysClk), .reset(reset), .asyncIn(asyncIn), .softReset(softReset),
        .syncOut(syncOut), .riseEdge(riseEdge), .fallEdge(fallEdge), .regReset(regReset)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passCnt++;
    endtask

    // Model: a sample delay line of ST edges, then the level-adoption rule, then the pulse counter.
    logic [CH-1:0] mSync, mRise, mFall, mS, mNext;
    logic          mReg;
    int            mCnt;
    int            mRun [CH];
    logic [CH-1:0] hist [$];

    always @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            mSync = IDLEV; mRise = '0; mFall = '0; mReg = 1'b1; mCnt = RP;
            hist = {};
            for (int i = 0; i < ST; i++) hist.push_back(IDLEV);
            for (int c = 0; c < CH; c++) mRun[c] = 0;
        end else begin
            mS = hist[ST-1];
            hist.push_front(asyncIn);
            void'(hist.pop_back());
            mNext = mS;
`ifdef SYNC_FILTER_EN
            for (int c = 0; c < CH; c++) begin
                mNext[c] = mSync[c];
                if (mS[c] == mSync[c]) mRun[c] = 0;
                else begin
                    mRun[c]++;
                    if (mRun[c] >= FL) begin
                        mNext[c] = mS[c];
                        mRun[c] = 0;
                    end
                end
            end
`endif
            if (softReset) mCnt = RP;
            else if (mCnt > 0) mCnt--;
            mReg  = (mCnt != 0);
            mRise = mReg ? '0 : (mNext & ~mSync);
            mFall = mReg ? '0 : (~mNext & mSync);
            mSync = mNext;
        end
    end

    always @(negedge sysClk) begin
        if (cmpEn) begin
            chk("m_syncOut", syncOut, mSync);
            chk("m_riseEdge", riseEdge, mRise);
            chk("m_fallEdge", fallEdge, mFall);
            chk("m_regReset", regReset, mReg);
        end
    end

    int n, nr, nf, k;

    initial begin
        // 1: reset held 3 cycles, then pulse length after release
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        cmpEn = 1;
        chk("rst_syncOut", syncOut, 2'b11);
        chk("rst_regReset", regReset, 1);
        chk("rst_strobes", {riseEdge, fallEdge}, 0);
        reset = 1'b1;
        n = 0; nr = 0;
        for (int i = 0; i < 40; i++) begin
            if (!regReset) break;
            n++;
            nr += (riseEdge != 0 || fallEdge != 0) ? 1 : 0;
            @(negedge sysClk);
        end
        chk("pulse_len", n, 16);
        chk("pulse_no_strobe", nr, 0);

        // 2: channel 0 falls; latency and single-cycle strobe
        asyncIn = 2'b10;
        repeat (LAT - 1) @(negedge sysClk);
        chk("lat_before", syncOut, 2'b11);
        @(negedge sysClk);
        chk("lat_at", syncOut, 2'b10);
        chk("lat_fall", fallEdge, 2'b01);
        chk("lat_rise", riseEdge, 2'b00);
        @(negedge sysClk);
        chk("fall_one_cycle", fallEdge, 2'b00);
        chk("ch1_unchanged", syncOut[1], 1'b1);

        // 3: short glitch, then a 6-cycle low
        asyncIn = 2'b11;
        repeat (12) @(negedge sysClk);
        asyncIn = 2'b10;
        nf = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) asyncIn = 2'b11;
            @(negedge sysClk);
            nf += fallEdge[0];
        end
        chk("glitch_falls", nf, GLITCH_FALLS);
        asyncIn = 2'b10;
        nf = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) asyncIn = 2'b11;
            @(negedge sysClk);
            nf += fallEdge[0];
            nr += riseEdge[0];
        end
        chk("long_low_falls", nf, 1);
        chk("long_low_rises", nr, 1);

        // 5: both channels rise together
        asyncIn = 2'b00;
        repeat (12) @(negedge sysClk);
        asyncIn = 2'b11;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sysClk);
            if (riseEdge != 0) begin k = i; break; end
        end
        chk("dual_rise_lat", k, LAT);
        chk("dual_rise_val", riseEdge, 2'b11);
        @(negedge sysClk);
        chk("dual_rise_clear", riseEdge, 2'b00);

        // 4: softReset at cycle 10 of a fresh pulse
        repeat (4) @(negedge sysClk);
        #2 reset = 1'b0;
        @(negedge sysClk);
        reset = 1'b1;
        repeat (10) @(negedge sysClk);
        chk("mid_pulse_reg", regReset, 1);
        softReset = 1'b1;
        @(negedge sysClk);
        softReset = 1'b0;
        asyncIn = 2'b00;
        n = 0; nr = 0;
        for (int i = 0; i < 40; i++) begin
            if (!regReset) break;
            n++;
            nr += (riseEdge != 0 || fallEdge != 0) ? 1 : 0;
            @(negedge sysClk);
        end
        chk("soft_pulse_len", n, 16);
        chk("soft_no_strobe", nr, 0);
        chk("soft_tracked", syncOut, 2'b00);

        // 6: reset mid-count aborts immediately
        asyncIn = 2'b11;
        repeat (ST) @(negedge sysClk);
        #2 reset = 1'b0;
        #1;
        chk("abort_syncOut", syncOut, 2'b11);
        chk("abort_regReset", regReset, 1);
        chk("abort_strobes", {riseEdge, fallEdge}, 0);
        @(negedge sysClk);
        reset = 1'b1;
        asyncIn = 2'b01;
        repeat (30) @(negedge sysClk);
        chk("post_abort_sync", syncOut, 2'b01);

        cmpEn = 0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
